// File: rtl/alu_seq_multiplier.sv
// Sequential shift-and-add multiplier: the multi-cycle MUL unit of the ALU.
// Ports: clk, reset (sync, active-high), start, a, b -> busy, done, product.
// Optional build macro SIGNED_MULT_EN adds input signed_op (two's complement).
module alu_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MULT_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_add;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_a_cap;
  logic [WIDTH-1:0]   w_b_cap;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_last = (r_cnt == LAST);

  // One step: add the multiplicand into the high half when the
  // current multiplier LSB is set, keep the carry, shift right.
  assign w_add    = r_p[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_add};
  assign w_p_next = {w_sum, r_p[WIDTH-1:1]};

`ifdef SIGNED_MULT_EN
  logic r_neg;
  logic w_neg_cap;

  // Magnitudes; the most negative value maps onto itself, which is
  // already its correct unsigned magnitude.
  assign w_a_cap   = (signed_op & a[WIDTH-1]) ? -a : a;
  assign w_b_cap   = (signed_op & b[WIDTH-1]) ? -b : b;
  assign w_neg_cap = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_result  = r_neg ? -w_p_next : w_p_next;

  always_ff @(posedge clk) begin
    if (reset)         r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg_cap;
  end
`else
  assign w_a_cap  = a;
  assign w_b_cap  = b;
  assign w_result = w_p_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_mcand <= w_a_cap;
      r_p     <= {{WIDTH{1'b0}}, w_b_cap};
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) product <= w_result;
    end
  end

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Self-checking bench for alu_seq_multiplier (scoreboard queue of
// expected products, popped when done pulses).
module tb_alu_seq_multiplier;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
`ifdef SIGNED_MULT_EN
  logic          signed_op;
`endif
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int vecs = 0;
  int errs = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  alu_seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef SIGNED_MULT_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] model(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic sg);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    if (sg) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic drive(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic sg);
    a     = ia;
    b     = ib;
`ifdef SIGNED_MULT_EN
    signed_op = sg;
`endif
    start = 1'b1;
    sb_q.push_back(model(ia, ib, sg));
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic sg);
    drive(ia, ib, sg);
    tick();
    start = 1'b0;
  endtask

  // Waits for done, pops the scoreboard, checks product, latency,
  // busy cycles, pulse width and that product holds afterwards.
  task automatic wait_result(input int exp_lat, input string nm);
    int lat;
    int bc;
    logic [2*W-1:0] exp;
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
      if (busy) bc++;
    end
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1",
               nm, done, lat);
    end
    vecs++;
    if (sb_q.size() == 0) begin
      errs++;
      $display("FAIL %s scoreboard: queue empty, required an entry", nm);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    vecs++;
    if (product !== exp)
      begin errs++; $display("FAIL %s product: got %h, required %h",
                             nm, product, exp); end
    vecs++;
    if (lat != exp_lat)
      begin errs++; $display("FAIL %s latency: got %0d, required %0d",
                             nm, lat, exp_lat); end
    vecs++;
    if (bc != exp_lat)
      begin errs++; $display("FAIL %s busy cycles: got %0d, required %0d",
                             nm, bc, exp_lat); end
    tick();
    vecs++;
    if (done !== 1'b0)
      begin errs++; $display("FAIL %s done width: got %b, required 0",
                             nm, done); end
    vecs++;
    if (product !== exp)
      begin errs++; $display("FAIL %s hold: got %h, required %h",
                             nm, product, exp); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SIGNED_MULT_EN
    signed_op = 1'b0;
`endif
    tick();
    tick();
    vecs++;
    if ({busy, done, product} !== {2'b00, 64'h0})
      begin errs++; $display("FAIL reset: busy=%b done=%b product=%h, required 0 0 0",
                             busy, done, product); end
    reset = 1'b0;
    tick();
    vecs++;
    if ({busy, done} !== 2'b00)
      begin errs++; $display("FAIL idle: busy=%b done=%b, required 0 0",
                             busy, done); end
  endtask

  task automatic test_basic();
    issue(32'd3, 32'd5, 1'b0);
    wait_result(W, "3x5");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_result(W, "maxsq");
    issue(32'h0, 32'h1234_5678, 1'b0);
    wait_result(W, "0xb");
    issue(32'h1234_5678, 32'h0, 1'b0);
    wait_result(W, "ax0");
    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom, 1'b0);
      wait_result(W, "rand");
    end
  endtask

  task automatic test_ignore_start();
    issue(32'd1000, 32'd2000, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    a     = 32'd7;
    b     = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result(W - 10, "ignored");
    vecs++;
    if (busy !== 1'b0)
      begin errs++; $display("FAIL ignored requeue: busy=%b, required 0", busy); end
    issue(32'd7, 32'd7, 1'b0);
    wait_result(W, "7x7");
  endtask

  task automatic test_reset_abort();
    int seen;
    issue(32'd123, 32'd456, 1'b0);
    void'(sb_q.pop_back());
    for (int i = 0; i < 15; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if ({busy, done, product} !== {2'b00, 64'h0})
      begin errs++; $display("FAIL abort: busy=%b done=%b product=%h, required 0 0 0",
                             busy, done, product); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    vecs++;
    if (seen != 0)
      begin errs++; $display("FAIL abort done: got %0d pulses, required 0", seen); end
    issue(32'd2, 32'd9, 1'b0);
    wait_result(W, "2x9");
  endtask

  task automatic test_back_to_back();
    drive(32'd3, 32'd5, 1'b0);
    tick();
    a = 32'd6;
    b = 32'd7;
    sb_q.push_back(model(32'd6, 32'd7, 1'b0));
    wait_result(W, "b2b first");
    tick();
    start = 1'b0;
    vecs++;
    if (busy !== 1'b1)
      begin errs++; $display("FAIL b2b reaccept: busy=%b, required 1", busy); end
    wait_result(W, "b2b second");
  endtask

`ifdef SIGNED_MULT_EN
  task automatic test_signed();
    issue(-32'sd3, 32'd5, 1'b1);
    wait_result(W, "s -3x5");
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_result(W, "s minsq");
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_result(W, "u minsq");
    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom, 1'b1);
      wait_result(W, "s rand");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef SIGNED_MULT_EN
    test_signed();
`endif
    vecs++;
    if (sb_q.size() != 0)
      begin errs++; $display("FAIL leftover: %0d entries, required 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
